// File: rtl/fpu_wb_pkg.sv
// Shared types and width constants for the FP writeback scheduler.
package fpu_wb_pkg;

    localparam int BR_W   = 20;
    localparam int DATA_W = 65;
    localparam int ROB_W  = 7;
    localparam int PREG_W = 7;

    typedef enum logic {
        SCHED_NORMAL,
        SCHED_THROTTLE
    } sched_state_e;

    typedef enum logic {
        WB_SRC_FIX,
        WB_SRC_DIV
    } wb_src_e;

endpackage

// File: rtl/fpu_wb_slot_tracker.sv
// Reservation shift register: one bit per accepted fixed-latency issue, reaching
// the MSB in the same cycle the op's response appears at the pipeline output.
module fpu_wb_slot_tracker #(
    parameter int FIXED_LAT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_issue_fire,
    output logic o_slot_busy
);

    logic [FIXED_LAT-1:0] r_occ;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_occ <= '0;
        end else begin
            r_occ <= {r_occ[FIXED_LAT-2:0], i_issue_fire};
        end
    end

    assign o_slot_busy = r_occ[FIXED_LAT-1];

endmodule

// File: rtl/fpu_wb_scheduler.sv
// Arbitrates the single FP writeback port between the fixed-latency FPU pipeline
// (always wins) and the div/sqrt unit, throttling fixed issue when div starves.
module fpu_wb_scheduler #(
    parameter int FIXED_LAT    = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int BR_W         = fpu_wb_pkg::BR_W,
    parameter int DATA_W       = fpu_wb_pkg::DATA_W,
    parameter int ROB_W        = fpu_wb_pkg::ROB_W,
    parameter int PREG_W       = fpu_wb_pkg::PREG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fix_issue_valid,
    output logic              fix_issue_ready,
    input  logic              fix_resp_valid,
    input  logic [DATA_W-1:0] fix_resp_data,
    input  logic [PREG_W-1:0] fix_resp_pdst,
    input  logic [ROB_W-1:0]  fix_resp_rob_idx,
    input  logic              fix_resp_fflags_valid,
    input  logic [4:0]        fix_resp_fflags,
    input  logic              div_resp_valid,
    output logic              div_resp_ready,
    input  logic [BR_W-1:0]   div_resp_br_mask,
    input  logic [DATA_W-1:0] div_resp_data,
    input  logic [PREG_W-1:0] div_resp_pdst,
    input  logic [ROB_W-1:0]  div_resp_rob_idx,
    input  logic [4:0]        div_resp_fflags,
    input  logic [BR_W-1:0]   brupdate_mispredict_mask,
    input  logic [BR_W-1:0]   brupdate_resolve_mask,
    output logic              wb_valid,
    output logic              wb_src,
    output logic [DATA_W-1:0] wb_data,
    output logic [PREG_W-1:0] wb_pdst,
    output logic [ROB_W-1:0]  wb_rob_idx,
    output logic [BR_W-1:0]   wb_br_mask,
    output logic              wb_fflags_valid,
    output logic [4:0]        wb_fflags,
    output logic              sched_err
);

    import fpu_wb_pkg::*;

    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_err;
    logic             w_slot_busy;
    logic             w_issue_ready;
    logic             w_issue_fire;
    logic             w_div_kill;
    logic             w_div_grant;
    logic             w_div_ready;
    logic             w_div_denied;
    wb_src_e          w_src;

    fpu_wb_slot_tracker #(
        .FIXED_LAT (FIXED_LAT)
    ) u_slot_tracker (
        .clock        (clock),
        .reset        (reset),
        .i_issue_fire (w_issue_fire),
        .o_slot_busy  (w_slot_busy)
    );

    // Handshakes are forced low while reset is held so nothing leaks out mid-reset.
    assign w_issue_ready = reset & (r_state == SCHED_NORMAL);
    assign w_issue_fire  = fix_issue_valid & w_issue_ready;
    assign w_div_kill    = div_resp_valid & (|(div_resp_br_mask & brupdate_mispredict_mask));
    assign w_div_grant   = reset & div_resp_valid & ~w_div_kill & ~w_slot_busy;
    assign w_div_ready   = w_div_grant | (reset & w_div_kill);
    assign w_div_denied  = div_resp_valid & ~w_div_ready;

    assign fix_issue_ready = w_issue_ready;
    assign div_resp_ready  = w_div_ready;
    assign wb_valid        = reset & (fix_resp_valid | w_div_grant);
    assign sched_err       = r_err;

    always_comb begin
        w_src           = WB_SRC_FIX;
        wb_data         = fix_resp_data;
        wb_pdst         = fix_resp_pdst;
        wb_rob_idx      = fix_resp_rob_idx;
        wb_br_mask      = '0;
        wb_fflags_valid = fix_resp_fflags_valid;
        wb_fflags       = fix_resp_fflags;
        if (!fix_resp_valid && w_div_grant) begin
            w_src           = WB_SRC_DIV;
            wb_data         = div_resp_data;
            wb_pdst         = div_resp_pdst;
            wb_rob_idx      = div_resp_rob_idx;
            wb_br_mask      = div_resp_br_mask & ~brupdate_resolve_mask;
            wb_fflags_valid = 1'b1;
            wb_fflags       = div_resp_fflags;
        end
    end

    assign wb_src = w_src;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (fix_resp_valid && !w_slot_busy) begin
            r_err <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (!w_div_denied) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != CNT_MAX) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= SCHED_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Throttling only blocks new issues; in-flight reservations drain within FIXED_LAT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCHED_NORMAL: begin
                if (w_div_denied && (r_wait_cnt == CNT_MAX)) begin
                    w_state_nxt = SCHED_THROTTLE;
                end
            end
            SCHED_THROTTLE: begin
                if (!w_div_denied) begin
                    w_state_nxt = SCHED_NORMAL;
                end
            end
            default: w_state_nxt = SCHED_NORMAL;
        endcase
    end

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// Randomised and directed bench for fpu_wb_scheduler against a cycle-level
// behavioural model built from issue history and denial streaks.
module tb_fpu_wb_scheduler;

    localparam int FL     = 4;
    localparam int SL     = 8;
    localparam int BR_W   = 20;
    localparam int DATA_W = 65;
    localparam int ROB_W  = 7;
    localparam int PREG_W = 7;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              fix_issue_valid = 1'b0;
    logic              fix_issue_ready;
    logic              fix_resp_valid = 1'b0;
    logic [DATA_W-1:0] fix_resp_data = '0;
    logic [PREG_W-1:0] fix_resp_pdst = '0;
    logic [ROB_W-1:0]  fix_resp_rob_idx = '0;
    logic              fix_resp_fflags_valid = 1'b0;
    logic [4:0]        fix_resp_fflags = '0;
    logic              div_resp_valid = 1'b0;
    logic              div_resp_ready;
    logic [BR_W-1:0]   div_resp_br_mask = '0;
    logic [DATA_W-1:0] div_resp_data = '0;
    logic [PREG_W-1:0] div_resp_pdst = '0;
    logic [ROB_W-1:0]  div_resp_rob_idx = '0;
    logic [4:0]        div_resp_fflags = '0;
    logic [BR_W-1:0]   brupdate_mispredict_mask = '0;
    logic [BR_W-1:0]   brupdate_resolve_mask = '0;
    logic              wb_valid;
    logic              wb_src;
    logic [DATA_W-1:0] wb_data;
    logic [PREG_W-1:0] wb_pdst;
    logic [ROB_W-1:0]  wb_rob_idx;
    logic [BR_W-1:0]   wb_br_mask;
    logic              wb_fflags_valid;
    logic [4:0]        wb_fflags;
    logic              sched_err;

    fpu_wb_scheduler #(
        .FIXED_LAT    (FL),
        .STARVE_LIMIT (SL),
        .BR_W         (BR_W),
        .DATA_W       (DATA_W),
        .ROB_W        (ROB_W),
        .PREG_W       (PREG_W)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .fix_issue_valid          (fix_issue_valid),
        .fix_issue_ready          (fix_issue_ready),
        .fix_resp_valid           (fix_resp_valid),
        .fix_resp_data            (fix_resp_data),
        .fix_resp_pdst            (fix_resp_pdst),
        .fix_resp_rob_idx         (fix_resp_rob_idx),
        .fix_resp_fflags_valid    (fix_resp_fflags_valid),
        .fix_resp_fflags          (fix_resp_fflags),
        .div_resp_valid           (div_resp_valid),
        .div_resp_ready           (div_resp_ready),
        .div_resp_br_mask         (div_resp_br_mask),
        .div_resp_data            (div_resp_data),
        .div_resp_pdst            (div_resp_pdst),
        .div_resp_rob_idx         (div_resp_rob_idx),
        .div_resp_fflags          (div_resp_fflags),
        .brupdate_mispredict_mask (brupdate_mispredict_mask),
        .brupdate_resolve_mask    (brupdate_resolve_mask),
        .wb_valid                 (wb_valid),
        .wb_src                   (wb_src),
        .wb_data                  (wb_data),
        .wb_pdst                  (wb_pdst),
        .wb_rob_idx               (wb_rob_idx),
        .wb_br_mask               (wb_br_mask),
        .wb_fflags_valid          (wb_fflags_valid),
        .wb_fflags                (wb_fflags),
        .sched_err                (sched_err)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: which cycles had an accepted fixed issue, last cycle reset was
    // held, current run of denied div cycles, and the sticky error flag.
    bit acc [0:8191];
    int t        = 0;
    int rst_mark = -1;
    int streak   = 0;
    bit m_err    = 1'b0;

    logic s_fir;
    logic s_dr;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, t, got, exp);
        end
    endtask

    function automatic bit m_busy();
        return (t >= FL) && (t - FL > rst_mark) && acc[t-FL];
    endfunction

    task automatic cyc(input bit rv, input bit fiv, input bit fv, input bit dv,
                       input logic [BR_W-1:0] mask, input logic [BR_W-1:0] misp,
                       input logic [BR_W-1:0] res);
        bit busy, thr, kill, grant, drdy, ewv, esrc;
        @(negedge clock);
        reset                    = rv;
        fix_issue_valid          = fiv;
        fix_resp_valid           = fv;
        fix_resp_data            = {1'($urandom), $urandom, $urandom};
        fix_resp_pdst            = 7'($urandom);
        fix_resp_rob_idx         = 7'($urandom);
        fix_resp_fflags_valid    = 1'($urandom);
        fix_resp_fflags          = 5'($urandom);
        div_resp_valid           = dv;
        div_resp_br_mask         = mask;
        div_resp_data            = {1'($urandom), $urandom, $urandom};
        div_resp_pdst            = 7'($urandom);
        div_resp_rob_idx         = 7'($urandom);
        div_resp_fflags          = 5'($urandom);
        brupdate_mispredict_mask = misp;
        brupdate_resolve_mask    = res;
        if (!rv) begin
            m_err  = 1'b0;
            streak = 0;
        end
        busy  = rv && m_busy();
        thr   = streak >= SL;
        kill  = dv && (|(mask & misp));
        grant = rv && dv && !kill && !busy;
        drdy  = grant || (rv && kill);
        ewv   = rv && (fv || grant);
        esrc  = !fv;
        #1;
        check("fix_issue_ready", fix_issue_ready, rv && !thr);
        check("div_resp_ready", div_resp_ready, drdy);
        check("wb_valid", wb_valid, ewv);
        check("sched_err", sched_err, m_err);
        if (ewv) begin
            check("wb_src", wb_src, esrc);
            check("wb_data", wb_data, esrc ? div_resp_data : fix_resp_data);
            check("wb_pdst", wb_pdst, esrc ? div_resp_pdst : fix_resp_pdst);
            check("wb_rob_idx", wb_rob_idx, esrc ? div_resp_rob_idx : fix_resp_rob_idx);
            check("wb_br_mask", wb_br_mask, esrc ? (mask & ~res) : '0);
            check("wb_fflags_valid", wb_fflags_valid, esrc ? 1'b1 : fix_resp_fflags_valid);
            check("wb_fflags", wb_fflags, esrc ? div_resp_fflags : fix_resp_fflags);
        end
        s_fir = fix_issue_ready;
        s_dr  = div_resp_ready;
        @(posedge clock);
        if (!rv) begin
            acc[t]   = 1'b0;
            rst_mark = t;
            streak   = 0;
            m_err    = 1'b0;
        end else begin
            acc[t] = fiv && !thr;
            streak = (dv && !drdy) ? streak + 1 : 0;
            if (fv && !busy) m_err = 1'b1;
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, m_busy(), 0, '0, '0, '0);
    endtask

    initial begin
        logic [BR_W-1:0] rmask, rmisp;
        bit rfiv, rdv, rrv;

        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1, '0, '0, '0);
        idle(2);

        // Single fixed issue with div idle.
        cyc(1, 1, 0, 0, '0, '0, '0);
        idle(6);

        // Div result with no reservations: immediate grant.
        cyc(1, 0, 0, 1, 20'h00010, '0, 20'h00010);
        check("div_idle_grant", s_dr, 1'b1);
        idle(2);

        // Back-to-back fixed issue with a div result always pending.
        for (int i = 0; i < 22; i++) begin
            cyc(1, 1, m_busy(), 1, 20'h00003, '0, 20'h00001);
            if (i == 11) check("b2b_issue_before_throttle", s_fir, 1'b1);
            if (i == 12) check("b2b_throttle", s_fir, 1'b0);
            if (i == 15) check("b2b_div_denied_15", s_dr, 1'b0);
            if (i == 16) check("b2b_div_grant", s_dr, 1'b1);
            if (i == 17) check("b2b_normal", s_fir, 1'b1);
        end
        idle(6);

        // Kill while the slot is held by a fixed response.
        cyc(1, 1, 0, 0, '0, '0, '0);
        idle(3);
        cyc(1, 0, m_busy(), 1, 20'h00004, 20'h00004, '0);
        check("kill_consumed", s_dr, 1'b1);
        cyc(1, 0, 0, 1, 20'h00008, '0, '0);
        check("post_kill_grant", s_dr, 1'b1);
        idle(3);

        // Randomised traffic with occasional resets and mispredicts.
        for (int i = 0; i < 3000; i++) begin
            rrv   = ($urandom_range(0, 399) != 0);
            rfiv  = ($urandom_range(0, 3) != 0);
            rdv   = ($urandom_range(0, 3) != 0);
            rmask = (BR_W'(1) << $urandom_range(0, BR_W - 1)) | (BR_W'(1) << $urandom_range(0, BR_W - 1));
            rmisp = ($urandom_range(0, 9) == 0) ? (BR_W'(1) << $urandom_range(0, BR_W - 1)) : '0;
            cyc(rrv, rfiv, m_busy() && ($urandom_range(0, 7) != 0), rdv, rmask, rmisp,
                BR_W'($urandom));
        end
        idle(6);

        // Unreserved fixed response sets the sticky error.
        cyc(1, 0, 1, 0, '0, '0, '0);
        idle(4);
        check("err_sticky", sched_err, 1'b1);

        // Mid-operation reset drops stale reservations and clears the error.
        cyc(1, 1, 0, 0, '0, '0, '0);
        cyc(1, 1, 0, 0, '0, '0, '0);
        cyc(0, 1, 0, 0, '0, '0, '0);
        cyc(0, 1, 0, 0, '0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            cyc(1, 0, m_busy(), 1, 20'h00001, '0, '0);
            check("post_reset_grant", s_dr, 1'b1);
        end
        check("err_cleared", sched_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
